// File: rtl/tone_sequencer.sv
// tone_sequencer: plays a programmable note pattern from an internal RAM as a square wave on a buzzer pin
module tone_sequencer #(
  parameter int UNIT_CYC = 25_000_000,
  parameter int DEPTH    = 16,
  parameter int DIV_W    = 18,
  parameter int P0       = 190839,
  parameter int P1       = 170067,
  parameter int P2       = 151514,
  parameter int P3       = 143265,
  parameter int P4       = 127550,
  parameter int P5       = 113635,
  parameter int P6       = 101213,
  localparam int AW      = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [5:0]    wr_data,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  input  logic [AW-1:0] last_addr,
  input  logic          enable,
  output logic          beep,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);
  localparam int UW = $clog2(UNIT_CYC);
  typedef enum logic [1:0] {IDLE, LOAD, PLAY} state_t;
  state_t           state_q;
  logic [5:0]       mem_q [DEPTH];
  logic [AW-1:0]    note_idx_q;
  logic [2:0]       code_q;
  logic [2:0]       dur_q;
  logic [DIV_W-1:0] period_q;
  logic [DIV_W-1:0] freq_q;
  logic [UW-1:0]    unit_q;
  logic             beep_q;
  logic             busy_q;
  logic             done_q;
  logic [5:0]       entry;
  logic [DIV_W-1:0] ld_period;
  logic             unit_wrap;
  logic             note_end;
  logic             beep_d;
  assign entry     = mem_q[note_idx_q];
  assign ld_period = entry[5:3] == 3'd0 ? DIV_W'(P0) :
                     entry[5:3] == 3'd1 ? DIV_W'(P1) :
                     entry[5:3] == 3'd2 ? DIV_W'(P2) :
                     entry[5:3] == 3'd3 ? DIV_W'(P3) :
                     entry[5:3] == 3'd4 ? DIV_W'(P4) :
                     entry[5:3] == 3'd5 ? DIV_W'(P5) :
                     entry[5:3] == 3'd6 ? DIV_W'(P6) : '0;
  assign unit_wrap = unit_q == UW'(UNIT_CYC - 1);
  assign note_end  = unit_wrap && dur_q == 3'd0;
  assign beep_d    = enable && code_q != 3'd7 && freq_q >= (period_q >> 1);
  assign beep      = beep_q;
  assign busy      = busy_q;
  assign note_idx  = note_idx_q;
  assign done      = done_q;
  // Pattern RAM write port; contents survive reset so a pattern can be replayed
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end
  // Playback FSM: load an entry, time its tone and duration, then advance, wrap or finish
  always_ff @(posedge clk) begin
    if (!rst || stop) begin
      state_q <= IDLE;
      beep_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      if (!rst) begin
        note_idx_q <= '0;
        code_q     <= '0;
        dur_q      <= '0;
        period_q   <= '0;
        freq_q     <= '0;
        unit_q     <= '0;
      end
    end else begin
      done_q <= 1'b0;
      beep_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q    <= LOAD;
            busy_q     <= 1'b1;
            note_idx_q <= '0;
          end
        end
        LOAD: begin
          code_q   <= entry[5:3];
          dur_q    <= entry[2:0];
          period_q <= ld_period;
          freq_q   <= '0;
          unit_q   <= '0;
          state_q  <= PLAY;
        end
        PLAY: begin
          freq_q <= freq_q == period_q ? '0 : freq_q + DIV_W'(1);
          unit_q <= unit_wrap ? '0 : unit_q + UW'(1);
          if (unit_wrap && dur_q != 3'd0) dur_q <= dur_q - 3'd1;
          if (!note_end) begin
            beep_q <= beep_d;
          end else if (note_idx_q != last_addr) begin
            note_idx_q <= note_idx_q + AW'(1);
            state_q    <= LOAD;
          end else if (loop) begin
            note_idx_q <= '0;
            state_q    <= LOAD;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_tone_sequencer.sv
// tb_tone_sequencer: directed stimulus with a per-note scoreboard for tone_sequencer
module tb_tone_sequencer;
  localparam int AW = 4;
  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [5:0]    wr_data = '0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          loop = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          enable = 1'b1;
  logic          beep;
  logic          busy;
  logic [AW-1:0] note_idx;
  logic          done;
  int errors = 0;
  int checks = 0;
  typedef struct {int idx; int len; int highs; int maxrun; int kind; int lb;} rec_t;
  rec_t exp_q[$];

  tone_sequencer #(
    .UNIT_CYC(20), .DEPTH(16), .DIV_W(8),
    .P0(9), .P1(3), .P2(4), .P3(5), .P4(6), .P5(7), .P6(7)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .start(start), .stop(stop), .loop(loop), .last_addr(last_addr), .enable(enable),
    .beep(beep), .busy(busy), .note_idx(note_idx), .done(done)
  );

  always #5 clk = ~clk;

  // kind: 0 = followed by another note, 1 = ended with done pulse, 2 = aborted (no done)
  function automatic void push_exp(int idx, int len, int highs, int maxrun, int kind);
    rec_t r;
    r = '{idx, len, highs, maxrun, kind, 0};
    exp_q.push_back(r);
  endfunction

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // monitor: measures each busy segment (LOAD + PLAY of one entry) and scores it
  int   m_idx, m_len, m_highs, m_run, m_max, m_lb;
  logic prev_busy = 1'b0;

  task automatic close_seg(int kind);
    rec_t e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL unexpected_note: idx=%0d len=%0d highs=%0d kind=%0d", m_idx, m_len, m_highs, kind);
    end else begin
      e = exp_q.pop_front();
      if (e.idx != m_idx || e.len != m_len || e.highs != m_highs || e.maxrun != m_max || e.kind != kind || e.lb != m_lb) begin
        errors++;
        $display("FAIL note: got idx=%0d len=%0d highs=%0d maxrun=%0d kind=%0d lb=%0d, expected idx=%0d len=%0d highs=%0d maxrun=%0d kind=%0d lb=%0d",
                 m_idx, m_len, m_highs, m_max, kind, m_lb, e.idx, e.len, e.highs, e.maxrun, e.kind, e.lb);
      end
    end
  endtask

  always @(negedge clk) begin
    if (busy && prev_busy && int'(note_idx) != m_idx) close_seg(0);
    if (busy && (!prev_busy || int'(note_idx) != m_idx)) begin
      m_idx = int'(note_idx);
      m_len = 0;
      m_highs = 0;
      m_run = 0;
      m_max = 0;
      m_lb = int'(beep);
    end
    if (busy) begin
      m_len++;
      if (beep) begin
        m_highs++;
        m_run++;
      end else m_run = 0;
      if (m_run > m_max) m_max = m_run;
    end
    if (!busy && prev_busy) begin
      m_lb = m_lb | int'(beep);
      close_seg(done ? 1 : 2);
    end else if (done) begin
      errors++;
      checks++;
      $display("FAIL spurious_done: done=1 with busy=%0b prev_busy=%0b", busy, prev_busy);
    end
    if (!busy && beep) begin
      errors++;
      checks++;
      $display("FAIL idle_beep: beep=1 expected 0 while not busy");
    end
    prev_busy = busy;
  end

  task automatic wr(int a, logic [5:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idx(int v);
    int n = 0;
    while (!(busy && int'(note_idx) == v) && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 2000) begin
      errors++;
      checks++;
      $display("FAIL wait_idx: note_idx=%0d never reached %0d", note_idx, v);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 3000) begin
      errors++;
      checks++;
      $display("FAIL wait_idle: busy=%0b still set", busy);
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_beep", int'(beep), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_note_idx", int'(note_idx), 0);
    rst = 1'b1;
    // single DO note, one unit
    wr(0, 6'b000_000);
    last_addr = 4'd0;
    loop = 1'b0;
    push_exp(0, 21, 11, 6, 1);
    pulse_start();
    wait_idle();
    // three notes: DO x2, rest x1, XI x3
    wr(0, 6'b000_001);
    wr(1, 6'b111_000);
    wr(2, 6'b110_010);
    last_addr = 4'd2;
    push_exp(0, 41, 23, 6, 0);
    push_exp(1, 21, 0, 0, 0);
    push_exp(2, 61, 35, 5, 1);
    pulse_start();
    wait_idle();
    // loop over two entries, drop loop during the second pass of the last note
    last_addr = 4'd1;
    loop = 1'b1;
    push_exp(0, 41, 23, 6, 0);
    push_exp(1, 21, 0, 0, 0);
    push_exp(0, 41, 23, 6, 0);
    push_exp(1, 21, 0, 0, 1);
    pulse_start();
    wait_idx(1);
    wait_idx(0);
    wait_idx(1);
    loop = 1'b0;
    wait_idle();
    // stop mid-note, with an ignored start during PLAY
    last_addr = 4'd2;
    push_exp(0, 13, 6, 6, 2);
    pulse_start();
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    repeat (3) @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 stop = 1'b1;
    @(posedge clk);
    #1 stop = 1'b0;
    wait_idle();
    // stop and start together mid-note: stop wins, nothing restarts
    push_exp(0, 13, 6, 6, 2);
    pulse_start();
    repeat (12) @(posedge clk);
    #1 begin stop = 1'b1; start = 1'b1; end
    @(posedge clk);
    #1 begin stop = 1'b0; start = 1'b0; end
    repeat (30) @(posedge clk);
    #1;
    wait_idle();
    // mute for 15 cycles mid-note, rewrite the playing entry
    wr(0, 6'b000_001);
    last_addr = 4'd1;
    loop = 1'b1;
    push_exp(0, 41, 15, 6, 0);
    push_exp(1, 21, 0, 0, 0);
    push_exp(0, 21, 10, 5, 0);
    push_exp(1, 21, 0, 0, 1);
    pulse_start();
    repeat (9) @(posedge clk);
    #1 enable = 1'b0;
    repeat (15) @(posedge clk);
    #1 enable = 1'b1;
    wr(0, 6'b110_000);
    wait_idx(1);
    wait_idx(0);
    wait_idx(1);
    loop = 1'b0;
    wait_idle();
    // reset during note 1, then replay from preserved RAM
    wr(0, 6'b000_000);
    wr(1, 6'b000_000);
    last_addr = 4'd1;
    loop = 1'b0;
    push_exp(0, 21, 11, 6, 0);
    push_exp(1, 6, 0, 0, 2);
    pulse_start();
    wait_idx(1);
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    chk("rst_mid_note_idx", int'(note_idx), 0);
    chk("rst_mid_busy", int'(busy), 0);
    chk("rst_mid_beep", int'(beep), 0);
    chk("rst_mid_done", int'(done), 0);
    wait_idle();
    push_exp(0, 21, 11, 6, 0);
    push_exp(1, 21, 11, 6, 1);
    pulse_start();
    wait_idle();
    repeat (20) @(posedge clk);
    #1;
    chk("leftover_expected_notes", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
